// File: rtl/acia_stream_bridge.sv
// Fabric-side initiator for a 6850-style ACIA: init, status polling,
// RX capture into a valid/ready stream and TX writes from a stream.
module acia_stream_bridge #(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter logic [7:0]  CTRL_INIT     = 8'h14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pclk,
  output logic       acia_cs_n,
  output logic       acia_we_n,
  output logic       acia_rs,
  output logic [7:0] acia_din,
  input  logic [7:0] acia_dout,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err,
  output logic       init_done
);

  typedef enum logic [2:0] {
    INIT_RST,
    INIT_CFG,
    IDLE,
    STAT_RD,
    STAT_CAP,
    RX_RD,
    RX_CAP,
    TX_WR
  } state_t;

  localparam logic [7:0] POLL_LOAD = 8'(POLL_INTERVAL - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       cs_n_q;
  logic       we_n_q;
  logic       rs_q;
  logic [7:0] din_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       rx_err_q;
  logic       init_done_q;
  logic       txe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT_RST;
      cnt_q       <= 8'd0;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      rs_q        <= 1'b0;
      din_q       <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      init_done_q <= 1'b0;
      txe_q       <= 1'b0;
    end else begin
      if (rx_valid_q && rx_ready)
        rx_valid_q <= 1'b0;
      unique case (state_q)
        INIT_RST: begin
          // first cycle after reset only launches the master-reset write
          if (cs_n_q) begin
            cs_n_q <= 1'b0;
            we_n_q <= 1'b0;
            rs_q   <= 1'b0;
            din_q  <= 8'h03;
          end else if (pclk) begin
            state_q <= INIT_CFG;
            din_q   <= CTRL_INIT;
          end
        end
        INIT_CFG: begin
          if (pclk) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
            cs_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            din_q       <= 8'd0;
            cnt_q       <= POLL_LOAD;
          end
        end
        IDLE: begin
          if (cnt_q == 8'd0) begin
            state_q <= STAT_RD;
            cs_n_q  <= 1'b0;
            we_n_q  <= 1'b1;
            rs_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        STAT_RD: begin
          if (pclk) begin
            state_q <= STAT_CAP;
            cs_n_q  <= 1'b1;
          end
        end
        STAT_CAP: begin
          txe_q <= acia_dout[1];
          if (acia_dout[4] || acia_dout[5])
            rx_err_q <= 1'b1;
          if (acia_dout[0] && !rx_valid_q) begin
            state_q <= RX_RD;
            cs_n_q  <= 1'b0;
            we_n_q  <= 1'b1;
            rs_q    <= 1'b1;
          end else if (acia_dout[1] && tx_valid) begin
            state_q <= TX_WR;
            cs_n_q  <= 1'b0;
            we_n_q  <= 1'b0;
            rs_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
            cnt_q   <= POLL_LOAD;
          end
        end
        RX_RD: begin
          if (pclk) begin
            state_q <= RX_CAP;
            cs_n_q  <= 1'b1;
          end
        end
        RX_CAP: begin
          rx_data_q  <= acia_dout;
          rx_valid_q <= 1'b1;
          if (txe_q && tx_valid) begin
            state_q <= TX_WR;
            cs_n_q  <= 1'b0;
            we_n_q  <= 1'b0;
            rs_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
            cnt_q   <= POLL_LOAD;
          end
        end
        TX_WR: begin
          if (pclk) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            cnt_q   <= POLL_LOAD;
          end
        end
        default: begin
          state_q <= INIT_RST;
          cs_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign acia_cs_n = cs_n_q;
  assign acia_we_n = we_n_q;
  assign acia_rs   = rs_q;
  assign acia_din  = (state_q == TX_WR) ? tx_data : din_q;
  assign tx_ready  = (state_q == TX_WR) && pclk;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_err    = rx_err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_acia_stream_bridge.sv
// Directed bench for acia_stream_bridge with a small ACIA bus model.
// Access log entries are {we_n, rs, din}.
module tb_acia_stream_bridge;

  logic       clk;
  logic       reset;
  logic       pclk;
  logic       acia_cs_n;
  logic       acia_we_n;
  logic       acia_rs;
  logic [7:0] acia_din;
  logic [7:0] acia_dout;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_err;
  logic       init_done;

  acia_stream_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .pclk      (pclk),
    .acia_cs_n (acia_cs_n),
    .acia_we_n (acia_we_n),
    .acia_rs   (acia_rs),
    .acia_din  (acia_din),
    .acia_dout (acia_dout),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_err    (rx_err),
    .init_done (init_done)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] stat;
  logic [7:0] rxbyte;
  logic [9:0] acc_q[$];
  int         ts_q[$];
  int         cyc = 0;
  int         pclk_div = 1;
  int         ph = 0;
  int         txr_cnt = 0;
  bit         mon_en = 0;
  int         stab_bad = 0;
  int         hold_bad = 0;
  int         stall = 0;
  logic       prev_cs_n = 1'b1;
  logic       prev_pclk = 1'b0;
  logic [9:0] prev_bus = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    pclk = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      if (pclk_div == 0) pclk = 1'b0;
      else pclk = ((ph % pclk_div) == 0);
    end
  end

  initial acia_dout = 8'h00;
  always @(posedge clk) begin
    cyc++;
    if (!acia_cs_n && pclk) begin
      acc_q.push_back({acia_we_n, acia_rs, acia_din});
      ts_q.push_back(cyc);
      if (acia_we_n) acia_dout <= acia_rs ? rxbyte : stat;
    end
  end

  always @(negedge clk) begin
    if (tx_ready) txr_cnt++;
    if (mon_en) begin
      if (!acia_cs_n && !prev_cs_n &&
          {acia_we_n, acia_rs, acia_din} != prev_bus)
        stab_bad++;
      if (acia_cs_n && !prev_cs_n && !prev_pclk)
        hold_bad++;
      if (!acia_cs_n && !pclk)
        stall++;
    end
    prev_cs_n = acia_cs_n;
    prev_pclk = pclk;
    prev_bus  = {acia_we_n, acia_rs, acia_din};
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int count_wr();
    int c = 0;
    foreach (acc_q[i]) if (!acc_q[i][9]) c++;
    return c;
  endfunction

  function automatic logic [9:0] last_wr();
    logic [9:0] r = '1;
    foreach (acc_q[i]) if (!acc_q[i][9]) r = acc_q[i];
    return r;
  endfunction

  function automatic logic [9:0] acc_at(input int i);
    if (i < acc_q.size()) return acc_q[i];
    return '1;
  endfunction

  function automatic int ts_at(input int i);
    if (i < ts_q.size()) return ts_q[i];
    return -100;
  endfunction

  initial begin
    int n;
    bit found;
    int txr0;

    reset = 1'b1;
    stat = 8'h01;
    rxbyte = 8'hA5;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    rx_ready = 1'b0;
    step(3);
    chk("rst_csn", 32'(acia_cs_n), 32'd1);
    chk("rst_wen", 32'(acia_we_n), 32'd1);
    chk("rst_rs", 32'(acia_rs), 32'd0);
    chk("rst_din", 32'(acia_din), 32'd0);
    chk("rst_rxv", 32'(rx_valid), 32'd0);
    chk("rst_rxd", 32'(rx_data), 32'd0);
    chk("rst_err", 32'(rx_err), 32'd0);
    chk("rst_idone", 32'(init_done), 32'd0);
    chk("rst_txr", 32'(tx_ready), 32'd0);

    // init sequence
    acc_q.delete();
    ts_q.delete();
    reset = 1'b0;
    step(1);
    chk("i0_csn", 32'(acia_cs_n), 32'd0);
    chk("i0_bus", 32'({acia_we_n, acia_rs, acia_din}), 32'h003);
    chk("i0_idone", 32'(init_done), 32'd0);
    step(1);
    chk("i1_csn", 32'(acia_cs_n), 32'd0);
    chk("i1_bus", 32'({acia_we_n, acia_rs, acia_din}), 32'h014);
    step(1);
    chk("i2_idone", 32'(init_done), 32'd1);
    chk("i2_csn", 32'(acia_cs_n), 32'd1);
    chk("i_nacc", 32'(acc_q.size()), 32'd2);
    chk("i_acc0", 32'(acc_at(0)), 32'h003);
    chk("i_acc1", 32'(acc_at(1)), 32'h014);

    // receive
    acc_q.delete();
    ts_q.delete();
    n = 0;
    found = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (rx_valid) begin
        n = i;
        found = 1;
        break;
      end
    end
    chk("rx_wait", 32'(found), 32'd1);
    chk("rx_lat", 32'(n), 32'd20);
    chk("rx_data", 32'(rx_data), 32'hA5);
    chk("rx_acc0", 32'(acc_at(0)), 32'h200);
    chk("rx_acc1", 32'(acc_at(1)), 32'h300);
    acc_q.delete();
    ts_q.delete();
    step(22);
    chk("rx_hold_n", 32'(acc_q.size()), 32'd1);
    chk("rx_hold_op", 32'(acc_at(0)), 32'h200);
    chk("rx_hold_v", 32'(rx_valid), 32'd1);
    stat = 8'h00;
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    chk("rx_drain", 32'(rx_valid), 32'd0);

    // transmit
    acc_q.delete();
    ts_q.delete();
    txr0 = txr_cnt;
    stat = 8'h02;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (txr_cnt != txr0) begin
        found = 1;
        break;
      end
    end
    chk("tx_wait", 32'(found), 32'd1);
    stat = 8'h00;
    step(25);
    chk("tx_rdy_n", 32'(txr_cnt - txr0), 32'd1);
    chk("tx_nwr", 32'(count_wr()), 32'd1);
    chk("tx_bus", 32'(last_wr()), 32'h13C);
    tx_valid = 1'b0;

    // combined rx + tx in one pass
    acc_q.delete();
    ts_q.delete();
    txr0 = txr_cnt;
    rxbyte = 8'hC3;
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    stat = 8'h03;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (txr_cnt != txr0) begin
        found = 1;
        break;
      end
    end
    chk("cb_wait", 32'(found), 32'd1);
    tx_valid = 1'b0;
    stat = 8'h00;
    chk("cb_nacc", 32'(acc_q.size()), 32'd3);
    chk("cb_acc0", 32'(acc_at(0)), 32'h200);
    chk("cb_acc1", 32'(acc_at(1)), 32'h300);
    chk("cb_acc2", 32'(acc_at(2)), 32'h15A);
    chk("cb_gap_rx", 32'(ts_at(1) - ts_at(0)), 32'd2);
    chk("cb_gap_tx", 32'(ts_at(2) - ts_at(1)), 32'd2);
    chk("cb_rxd", 32'(rx_data), 32'hC3);
    chk("cb_rxv", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;

    // slow pclk
    pclk_div = 4;
    step(1);
    mon_en = 1;
    stat = 8'h30;
    found = 0;
    for (int i = 0; i < 150; i++) begin
      step(1);
      if (rx_err) begin
        found = 1;
        break;
      end
    end
    chk("sl_err_set", 32'(found), 32'd1);
    stat = 8'h00;
    step(80);
    chk("sl_err_stick", 32'(rx_err), 32'd1);
    acc_q.delete();
    ts_q.delete();
    txr0 = txr_cnt;
    stat = 8'h02;
    tx_data = 8'h96;
    tx_valid = 1'b1;
    found = 0;
    for (int i = 0; i < 150; i++) begin
      step(1);
      if (txr_cnt != txr0) begin
        found = 1;
        break;
      end
    end
    tx_valid = 1'b0;
    stat = 8'h00;
    chk("sl_tx_wait", 32'(found), 32'd1);
    chk("sl_tx_rdy", 32'(txr_cnt - txr0), 32'd1);
    chk("sl_tx_bus", 32'(last_wr()), 32'h196);
    step(8);
    mon_en = 0;
    chk("sl_stable", 32'(stab_bad), 32'd0);
    chk("sl_hold", 32'(hold_bad), 32'd0);
    chk("sl_stalled", 32'(stall != 0), 32'd1);

    // reset while TX_WR is stalled
    txr0 = txr_cnt;
    stat = 8'h02;
    tx_data = 8'h77;
    tx_valid = 1'b1;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!acia_cs_n && !acia_we_n && acia_rs && !pclk) begin
        found = 1;
        break;
      end
    end
    chk("rm_find", 32'(found), 32'd1);
    reset = 1'b1;
    pclk_div = 0;
    @(posedge clk);
    #1;
    chk("rm_csn", 32'(acia_cs_n), 32'd1);
    acc_q.delete();
    ts_q.delete();
    step(2);
    pclk_div = 1;
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (init_done) begin
        found = 1;
        break;
      end
    end
    chk("rm_init", 32'(found), 32'd1);
    chk("rm_first", 32'(acc_at(0)), 32'h003);
    chk("rm_second", 32'(acc_at(1)), 32'h014);
    chk("rm_no_txr", 32'(txr_cnt - txr0), 32'd0);
    tx_valid = 1'b0;
    stat = 8'h00;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acia_stream_bridge.md
# acia_stream_bridge

Bus-initiator companion to the 6850-style ACIA peripheral. It drives the ACIA register interface (cs_n / we_n / rs / data) on behalf of fabric logic: it initialises the control register, polls status, moves received bytes into a valid/ready output stream and writes bytes from a valid/ready input stream to the transmit data register. It sits between the ACIA and any non-CPU client, such as a loader or a debug monitor, that needs the serial port without the 6502.

## Interface
- POLL_INTERVAL, 16: idle cycles between status polls; legal range 1..255, 8-bit counter.
- CTRL_INIT, 8'h14: control byte written after master reset; 8N1, divide select 00, interrupts off.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pclk  in  1  ACIA peripheral strobe; the ACIA acts only in cycles where pclk=1.
- acia_cs_n  out  1  ACIA chip select, low-true.
- acia_we_n  out  1  ACIA write enable, low-true.
- acia_rs  out  1  register select: 0 = control/status, 1 = tx/rx data.
- acia_din  out  8  data to the ACIA.
- acia_dout  in  8  ACIA registered read data.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data valid; tx_data must stay stable until it is accepted.
- tx_ready  out  1  one-cycle accept pulse for tx_data.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data holding register full.
- rx_ready  in  1  consumer accepts rx_data.
- rx_err  out  1  sticky; set when a polled status has bit 4 or bit 5 set; cleared only by reset.
- init_done  out  1  high once both init writes have completed.

## Operation
- States: INIT_RST, INIT_CFG, IDLE, STAT_RD, STAT_CAP, RX_RD, RX_CAP, TX_WR.
- **Access states** are INIT_RST, INIT_CFG, STAT_RD, RX_RD and TX_WR.
  - In these states acia_cs_n=0 and the access is held until the **completion cycle**: the first cycle in the state with pclk=1.
  - The state advances on the clock edge that ends the completion cycle.
  - acia_cs_n returns to 1 in every non-access state.
- **Access encodings:**
  - INIT_RST: write, rs=0, din=8'h03 (master reset).
  - INIT_CFG: write, rs=0, din=CTRL_INIT.
  - STAT_RD: read, rs=0.
  - RX_RD: read, rs=1.
  - TX_WR: write, rs=1, din=tx_data.
  - Reads drive acia_we_n=1 and acia_din=0.
- **Init sequence:** INIT_RST → INIT_CFG → IDLE. init_done is set on the edge that leaves INIT_CFG.
- **IDLE:** the poll counter loads POLL_INTERVAL-1 on entry and decrements each cycle. At 0 the state goes to STAT_RD.
- **STAT_CAP** (one cycle) samples acia_dout as status, with bit0 = rxf and bit1 = txe.
  - If rxf=1 and rx_valid=0: go to RX_RD.
  - Else if txe=1 and tx_valid=1: go to TX_WR.
  - Else: go to IDLE.
  - Status bit 4 or bit 5 set → rx_err ← 1.
- **RX_CAP** (one cycle): rx_data ← acia_dout, rx_valid ← 1. Then go to TX_WR if the captured txe=1 and tx_valid=1, else go to IDLE.
- **TX_WR:** tx_ready=1 in the completion cycle only. Then go to IDLE.
- **RX stream:** rx_valid clears on any cycle with rx_valid & rx_ready.
  - While rx_valid=1 no RX_RD is issued. The byte stays in the ACIA, and ACIA overrun is the ACIA's concern; it is reported through rx_err on the next poll.
- **Simultaneous events:**
  - If rx_ready drains rx_valid in the STAT_CAP cycle, the decision uses the pre-edge rx_valid, so no RX_RD is issued that pass.
  - If rx_valid clears in the same cycle as the RX_CAP load, the load wins and rx_valid ends at 1.
- **tx_valid dropped** before completion: protocol violation. The write still completes with whatever tx_data holds; no recovery is required.
- **Reset mid-access:** on reset the state returns to INIT_RST and any partial access is abandoned, with cs_n high in the cycle after reset asserts. A full init is always replayed.

## Timing
- **Reset values:**
  - acia_cs_n=1, acia_we_n=1, acia_rs=0, acia_din=0.
  - tx_ready=0, rx_valid=0, rx_data=0, rx_err=0, init_done=0.
  - State is INIT_RST.
- All outputs are registered except acia_din in TX_WR (= tx_data) and tx_ready (= state==TX_WR & pclk).
- **Access length:** 1 cycle if pclk=1 on the first cycle; otherwise extends to the next pclk=1 cycle.
- **Read data:** the ACIA updates dout on the completion edge, so acia_dout is valid in the CAP cycle immediately after.
- **Latencies, pclk tied 1:**
  - Reset release → init_done = 2 cycles.
  - Poll period = POLL_INTERVAL + 2 cycles (IDLE + STAT_RD + STAT_CAP).
  - Byte available → rx_valid = at most POLL_INTERVAL + 4 cycles after entering IDLE.

## Test plan
- **Init:** pclk=1 and reset deasserted at cycle 0. Required:
  - INIT_RST writes 8'h03 with rs=0 in cycle 0.
  - INIT_CFG writes 8'h14 with rs=0 in cycle 1.
  - init_done=1 from cycle 2.
- **Receive:** ACIA model returns status 8'h01 then data 8'hA5, rx_ready=0. Required:
  - RX_RD issued; rx_data=8'hA5 and rx_valid=1.
  - The next poll with status 8'h01 issues no RX_RD.
  - A one-cycle rx_ready pulse clears rx_valid.
- **Transmit:** status 8'h02, tx_valid=1, tx_data=8'h3C. Required:
  - One write with rs=1, we_n=0, din=8'h3C.
  - tx_ready high for exactly 1 cycle.
  - The next poll with status 8'h00 issues no write.
- **Combined:** status 8'h03 with tx_valid=1 → RX_RD then RX_CAP then TX_WR, back-to-back, with no IDLE between them.
- **Slow pclk:** pclk high 1 cycle in 4. Required:
  - Every access holds cs_n low until a pclk=1 cycle, with rs/we_n/din stable throughout.
  - Status 8'h30 sets rx_err, which stays set through later clean polls.
- **Reset mid-TX_WR:** assert reset during a TX_WR stalled on pclk=0. Required:
  - cs_n=1 the next cycle and tx_ready never pulses.
  - After release, 8'h03 is written before any other access.
